// File: rtl/load_input_control_pkg.sv
// Shared definitions for the input-load and output-store control blocks:
// FSM state encoding and the tiling-related size derivations.
package load_input_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int num_submats(input int max_dim, input int arr_dim);
        return max_dim / arr_dim;
    endfunction

    // Step counter must reach rows-1 + cols-1 for a full array.
    function automatic int step_width(input int arr_rows, input int arr_cols);
        return $clog2(arr_rows + arr_cols);
    endfunction

    localparam int DEF_MAX_OUT_ROWS  = 128;
    localparam int DEF_MAX_OUT_COLS  = 128;
    localparam int DEF_SYS_ARR_ROWS  = 16;
    localparam int DEF_SYS_ARR_COLS  = 16;
    localparam int DEF_NUM_SUBMATS_M = num_submats(DEF_MAX_OUT_ROWS, DEF_SYS_ARR_ROWS);
    localparam int DEF_NUM_SUBMATS_N = num_submats(DEF_MAX_OUT_COLS, DEF_SYS_ARR_COLS);
    localparam int DEF_STEP_W        = step_width(DEF_SYS_ARR_ROWS, DEF_SYS_ARR_COLS);

endpackage

// File: rtl/load_input_control_skew_addr_gen.sv
// Combinational diagonal-skew read generator: column c reads row (step - c)
// of the submatrix while that row index lies inside the latched tile.
module skew_addr_gen
    import load_input_control_pkg::*;
#(
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int STEP_W       = 5
) (
    input  logic [STEP_W-1:0]                    step,
    input  logic [ADDR_WIDTH-1:0]                base,
    input  logic [$clog2(SYS_ARR_ROWS)-1:0]      r_max,
    input  logic [$clog2(SYS_ARR_COLS)-1:0]      c_max,
    output logic [SYS_ARR_COLS-1:0]              en,
    output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0]   addr
);

    for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_col
        localparam logic [STEP_W:0] COL = (STEP_W+1)'(c);
        logic [STEP_W:0] diff;

        assign diff  = {1'b0, step} - COL;
        assign en[c] = ({1'b0, step} >= COL)
                    && (COL  <= (STEP_W+1)'(c_max))
                    && (diff <= (STEP_W+1)'(r_max));
        // Address wraps silently at ADDR_WIDTH bits.
        assign addr[c*ADDR_WIDTH +: ADDR_WIDTH] = en[c] ? base + ADDR_WIDTH'(diff) : '0;
    end

endmodule

// File: rtl/load_input_control.sv
// Fetches one input submatrix from the per-column banks into the systolic
// array with a diagonal skew; all bank-facing outputs are registered.
module load_input_control
    import load_input_control_pkg::*;
#(
    parameter int  MAX_OUT_ROWS  = 128,
    parameter int  MAX_OUT_COLS  = 128,
    parameter int  SYS_ARR_ROWS  = 16,
    parameter int  SYS_ARR_COLS  = 16,
    parameter int  ADDR_WIDTH    = 8,
    localparam int NUM_SUBMATS_M = num_submats(MAX_OUT_ROWS, SYS_ARR_ROWS),
    localparam int NUM_SUBMATS_N = num_submats(MAX_OUT_COLS, SYS_ARR_COLS),
    localparam int STEP_W        = step_width(SYS_ARR_ROWS, SYS_ARR_COLS),
    localparam int SMR_W         = $clog2(NUM_SUBMATS_M),
    localparam int SMC_W         = $clog2(NUM_SUBMATS_N),
    localparam int RW            = $clog2(SYS_ARR_ROWS),
    localparam int CW            = $clog2(SYS_ARR_COLS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                done,
    input  logic [SMR_W-1:0]                    submat_row_in,
    input  logic [SMC_W-1:0]                    submat_col_in,
    output logic [SMR_W-1:0]                    submat_row_out,
    output logic [SMC_W-1:0]                    submat_col_out,
    input  logic [RW-1:0]                       num_rows_read,
    input  logic [CW-1:0]                       num_cols_read,
    input  logic [ADDR_WIDTH-1:0]               rd_base_addr,
    output logic [SYS_ARR_COLS-1:0]             rd_en,
    output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0]  rd_addr,
    output logic [SYS_ARR_COLS-1:0]             data_valid
);

    state_t                            state, state_next;
    logic [STEP_W-1:0]                 step, step_next, last_step;
    logic [RW-1:0]                     r_q, gen_r;
    logic [CW-1:0]                     c_q, gen_c;
    logic [ADDR_WIDTH-1:0]             base_q, gen_base;
    logic [SYS_ARR_COLS-1:0]           gen_en;
    logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] gen_addr;

    assign done      = (state == ST_IDLE);
    assign last_step = STEP_W'(r_q) + STEP_W'(c_q);

    // The generator sees next-cycle step/parameters so its registered
    // outputs line up with the FEED cycle they belong to.
    always_comb begin
        state_next = state;
        step_next  = step;
        gen_r      = r_q;
        gen_c      = c_q;
        gen_base   = base_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FEED;
                    step_next  = '0;
                    gen_r      = num_rows_read;
                    gen_c      = num_cols_read;
                    gen_base   = rd_base_addr;
                end
            end
            ST_FEED: begin
                if (step == last_step) state_next = ST_DRAIN;
                else                   step_next  = step + STEP_W'(1);
            end
            ST_DRAIN: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    skew_addr_gen #(
        .SYS_ARR_ROWS (SYS_ARR_ROWS),
        .SYS_ARR_COLS (SYS_ARR_COLS),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .STEP_W       (STEP_W)
    ) u_skew (
        .step  (step_next),
        .base  (gen_base),
        .r_max (gen_r),
        .c_max (gen_c),
        .en    (gen_en),
        .addr  (gen_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            step           <= '0;
            r_q            <= '0;
            c_q            <= '0;
            base_q         <= '0;
            submat_row_out <= '0;
            submat_col_out <= '0;
            rd_en          <= '0;
            rd_addr        <= '0;
            data_valid     <= '0;
        end else begin
            state  <= state_next;
            step   <= step_next;
            r_q    <= gen_r;
            c_q    <= gen_c;
            base_q <= gen_base;
            if (state == ST_IDLE && start) begin
                submat_row_out <= submat_row_in;
                submat_col_out <= submat_col_in;
            end
            rd_en      <= (state_next == ST_FEED) ? gen_en   : '0;
            rd_addr    <= (state_next == ST_FEED) ? gen_addr : '0;
            data_valid <= rd_en;
        end
    end

endmodule

// File: tb/tb_load_input_control.sv
// Directed bench for load_input_control: expected read vectors are queued at
// start and matched by a monitor whenever the DUT drives rd_en / data_valid.
module tb_load_input_control;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          done;
    logic [2:0]    submat_row_in, submat_col_in;
    logic [2:0]    submat_row_out, submat_col_out;
    logic [3:0]    num_rows_read, num_cols_read;
    logic [7:0]    rd_base_addr;
    logic [15:0]   rd_en;
    logic [127:0]  rd_addr;
    logic [15:0]   data_valid;

    logic [143:0]  exp_q[$];
    logic [15:0]   dv_q[$];
    int            checks = 0;
    int            errors = 0;

    load_input_control dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .done           (done),
        .submat_row_in  (submat_row_in),
        .submat_col_in  (submat_col_in),
        .submat_row_out (submat_row_out),
        .submat_col_out (submat_col_out),
        .num_rows_read  (num_rows_read),
        .num_cols_read  (num_cols_read),
        .rd_base_addr   (rd_base_addr),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .data_valid     (data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: column k reads row (s-k) when k<=C and 0<=s-k<=R.
    function automatic logic [143:0] model(input int s, input int r, input int c, input logic [7:0] base);
        logic [15:0]  en;
        logic [127:0] addr;
        en   = '0;
        addr = '0;
        for (int k = 0; k < 16; k++) begin
            if (k <= c && s >= k && s - k <= r) begin
                en[k]          = 1'b1;
                addr[k*8 +: 8] = base + 8'(s - k);
            end
        end
        return {en, addr};
    endfunction

    task automatic push_tile(input int r, input int c, input logic [7:0] base);
        logic [143:0] e;
        for (int s = 0; s <= r + c; s++) begin
            e = model(s, r, c, base);
            exp_q.push_back(e);
            dv_q.push_back(e[143:128]);
        end
    endtask

    task automatic launch(input int r, input int c, input logic [7:0] base,
                          input logic [2:0] srow, input logic [2:0] scol);
        submat_row_in = srow;
        submat_col_in = scol;
        num_rows_read = 4'(r);
        num_cols_read = 4'(c);
        rd_base_addr  = base;
        start         = 1'b1;
        push_tile(r, c, base);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_tile(input int r, input int c, input logic [7:0] base,
                            input logic [2:0] srow, input logic [2:0] scol,
                            input int busy_at, input int probe_step, input int probe_col,
                            input logic [7:0] probe_addr, input logic [15:0] probe_en);
        int n;
        launch(r, c, base, srow, scol);
        n = 1;
        while (!done && n < 100) begin
            if (n - 1 == probe_step) begin
                check("probe_rd_en", rd_en, probe_en);
                check("probe_rd_addr", rd_addr[probe_col*8 +: 8], probe_addr);
            end
            start = (n == busy_at);
            if (start) begin
                submat_row_in = ~srow;
                num_rows_read = 4'd0;
                num_cols_read = 4'd0;
                rd_base_addr  = 8'h99;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("done_latency", n, r + c + 3);
        check("submat_row_out", submat_row_out, srow);
        check("submat_col_out", submat_col_out, scol);
    endtask

    // Monitor: every nonzero read strobe must match the head of its queue.
    logic [143:0] mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en != 16'h0) begin
                if (exp_q.size() == 0) check("rd_unexpected", {rd_en, rd_addr}, 144'h0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("rd_en_addr", {rd_en, rd_addr}, mon_e);
                end
            end
            if (data_valid != 16'h0) begin
                if (dv_q.size() == 0) check("dv_unexpected", data_valid, 144'h0);
                else check("data_valid", data_valid, dv_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        submat_row_in = '0; submat_col_in = '0;
        num_rows_read = '0; num_cols_read = '0; rd_base_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_done", done, 1);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_submat_row", submat_row_out, 0);
        check("rst_submat_col", submat_col_out, 0);

        // start together with reset must be ignored
        reset = 1'b1; start = 1'b1; num_rows_read = 4'd3;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rst_start_done", done, 1);
        check("rst_start_rd_en", rd_en, 0);

        // full tile: step 20 has columns 5..15 active, col 15 at base+5
        run_tile(15, 15, 8'h10, 3'd2, 3'd5, -1, 20, 15, 8'h15, 16'hFFE0);
        // minimal tile
        run_tile(0, 0, 8'h00, 3'd1, 3'd1, -1, 0, 0, 8'h00, 16'h0001);
        // column masking: step 5 only column 2, row 3
        run_tile(3, 2, 8'h40, 3'd3, 3'd4, -1, 5, 2, 8'h43, 16'h0004);
        // address wrap: third read of column 0 wraps to 0x00
        run_tile(3, 0, 8'hFE, 3'd6, 3'd0, -1, 2, 0, 8'h00, 16'h0001);
        // busy start at step 9 must not disturb the transfer
        run_tile(15, 15, 8'h20, 3'd4, 3'd3, 10, 3, 0, 8'h23, 16'h000F);

        // mid-operation reset at step 5
        launch(15, 15, 8'h10, 3'd7, 3'd7);
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_rd_en", rd_en, 0);
        check("abort_data_valid", data_valid, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_done", done, 1);
        exp_q.delete();
        dv_q.delete();
        @(posedge clk); #1;
        check("abort_idle_rd_en", rd_en, 0);
        run_tile(15, 15, 8'h80, 3'd5, 3'd2, -1, 30, 15, 8'h8F, 16'h8000);

        repeat (3) begin @(posedge clk); #1; end
        check("exp_q_drained", exp_q.size(), 0);
        check("dv_q_drained", dv_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_input_control.md
Name: load_input_control

Overview:
- Read-side counterpart of the output store control.
- On start, fetches one input submatrix from the input memory banks, one row per cycle, and feeds it into the systolic array.
- Per-column reads are skewed diagonally: column c lags column 0 by c cycles, so the array receives wavefront-aligned operands.
- Sits between the master control sequencer and the per-column input memory banks.

Parameters:
- MAX_OUT_ROWS, 128, max rows of the full matrix.
- MAX_OUT_COLS, 128, max cols of the full matrix.
- SYS_ARR_ROWS, 16, systolic array rows; max submatrix rows.
- SYS_ARR_COLS, 16, systolic array cols; one memory bank per column.
- ADDR_WIDTH, 8, per-bank address width.
- Derived localparams:
  - NUM_SUBMATS_M = MAX_OUT_ROWS/SYS_ARR_ROWS
  - NUM_SUBMATS_N = MAX_OUT_COLS/SYS_ARR_COLS
  - STEP_W = $clog2(SYS_ARR_ROWS+SYS_ARR_COLS)

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle launch pulse; honoured only when idle.
- done  out  1  high when idle.
- submat_row_in  in  $clog2(NUM_SUBMATS_M)  submatrix row index.
- submat_col_in  in  $clog2(NUM_SUBMATS_N)  submatrix col index.
- submat_row_out  out  $clog2(NUM_SUBMATS_M)  index latched at start.
- submat_col_out  out  $clog2(NUM_SUBMATS_N)  index latched at start.
- num_rows_read  in  $clog2(SYS_ARR_ROWS)  rows minus 1 (0-15 means 1-16).
- num_cols_read  in  $clog2(SYS_ARR_COLS)  cols minus 1.
- rd_base_addr  in  ADDR_WIDTH  bank address of row 0.
- rd_en  out  SYS_ARR_COLS  per-bank read enable.
- rd_addr  out  SYS_ARR_COLS*ADDR_WIDTH  per-bank read address; bank c occupies bits [c*ADDR_WIDTH +: ADDR_WIDTH].
- data_valid  out  SYS_ARR_COLS  per-column strobe; bank read data is valid at the array this cycle.

Behaviour:
- Reset (sync, active-high):
  - state goes to IDLE; step = 0.
  - rd_en = 0, data_valid = 0, rd_addr = 0.
  - submat_row_out = 0, submat_col_out = 0.
  - done = 1.
  - Reset mid-operation aborts immediately; no further rd_en is issued.
- States:
  - IDLE to FEED: on start. Latch num_rows_read, num_cols_read, rd_base_addr and the submat indices; step = 0.
  - FEED: step increments by 1 per cycle. When step == R+C (latched rows-1 plus cols-1), go to DRAIN next cycle.
  - DRAIN: exactly one cycle, covering the 1-cycle memory read latency. Then go to IDLE.
- done = (state == IDLE). A start asserted in FEED or DRAIN is ignored; nothing is queued.
- rd_en[c] is high in FEED iff all of the following hold:
  - c <= C
  - step >= c
  - step - c <= R
  - rd_en[c] = 0 for all c > C.
- Addressing: rd_addr[c] = rd_base_addr + (step - c), truncated to ADDR_WIDTH. Address wrap-around is permitted and silent. When rd_en[c] = 0, rd_addr[c] holds 0.
- Latency and valid: data_valid = rd_en delayed by one cycle (registered). It is 0 in IDLE, except in the cycle immediately after the last FEED cycle, which is the DRAIN cycle.
- FEED length is R+C+1 cycles. Total from start to done=1 is R+C+3 cycles: 1 latch cycle, R+C+1 FEED cycles, 1 DRAIN cycle.
- Outputs rd_en, rd_addr and data_valid are registered; there is no combinational path from start.
- Simultaneous start and reset: reset wins.
- Inputs other than start are sampled only on the start cycle; changes after that are ignored.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, FEED, DRAIN)
  - the NUM_SUBMATS_M, NUM_SUBMATS_N and STEP_W derivations, shared with the output store control.
- One sub-module: skew_addr_gen. It takes step, base, R and C and produces rd_en and rd_addr for all columns. It is a generate loop over c and is purely combinational.
- The top level registers its outputs.

Test Plan:
- Full tile: start with R=15, C=15, base=0x10.
  - rd_en[0] high for FEED steps 0-15; rd_en[15] high for steps 15-30.
  - rd_addr[15] at step 20 = 0x15.
  - data_valid mirrors rd_en one cycle later.
  - done rises 33 cycles after start.
- Minimal tile: R=0, C=0, base=0x00.
  - Single rd_en[0] pulse with rd_addr[0]=0x00.
  - data_valid[0] pulses the next cycle.
  - done returns after 3 cycles.
- Column masking: R=3, C=2.
  - rd_en[15:3] never asserted.
  - rd_en[2] high at steps 2-5 with addresses base+0 through base+3.
- Address wrap: base=0xFE, R=3.
  - rd_addr[0] sequence is 0xFE, 0xFF, 0x00, 0x01.
- Busy start: second start pulse mid-FEED.
  - Ignored; transfer length unchanged; submat_row_out unchanged.
- Mid-operation reset: reset at step 5 of a full tile.
  - The next cycle shows rd_en=0, data_valid=0, done=1.
  - A fresh start afterwards runs a complete, correct sequence.
